// File: rtl/gsim_result_fmt_pkg.sv
// Shared definitions for the Gauss-Seidel result formatter: FSM encoding and default frame geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gsim_result_fmt_pkg;

   // Default frame geometry; the solver emits Q16.16 words in the same format.
   localparam int GSIM_N     = 16;
   localparam int GSIM_IN_W  = 32;
   localparam int GSIM_FRAC  = 16;
   localparam int GSIM_OUT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } gsim_state_t;

endpackage

// File: rtl/q_round_sat.sv
// Round a signed fixed-point word to the nearest integer (ties toward +inf) and clip to OUT_W bits.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module q_round_sat #(
   parameter int IN_W  = 32,
   parameter int FRAC  = 16,
   parameter int OUT_W = 16
) (
   input  logic [IN_W-1:0]  x_in,
   output logic [OUT_W-1:0] q_val,
   output logic             q_sat
);

   // One extra bit of headroom so adding one half LSB can never wrap.
   localparam logic signed [IN_W:0] HALF =
      {1'b0, {(IN_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

   logic signed [IN_W:0] s_sum;
   logic signed [IN_W:0] q_full;
   logic [IN_W-OUT_W+1:0] q_hi;

   assign s_sum  = $signed({x_in[IN_W-1], x_in}) + HALF;
   assign q_full = s_sum >>> FRAC;
   // Bits that must all match the sign for the value to fit in OUT_W.
   assign q_hi   = q_full[IN_W:OUT_W-1];

   // Pass the value through when it fits, otherwise clip to the extreme of its sign.
   always_comb begin
      q_val = q_full[OUT_W-1:0];
      q_sat = 1'b0;
      if (!((&q_hi) || !(|q_hi))) begin
         q_sat = 1'b1;
         if (q_full[IN_W]) begin
            q_val = {1'b1, {(OUT_W-1){1'b0}}};
         end else begin
            q_val = {1'b0, {(OUT_W-1){1'b1}}};
         end
      end
   end

endmodule

// File: rtl/gsim_result_fmt.sv
// Capture one N-word frame from the solver, round/saturate each word, then drain it over valid/ready.
// Latency: first word presented N cycles after the first accepted input (gap-free input).
// Backpressure: out_ready low stalls the drain with data held stable; input is never backpressured.
module gsim_result_fmt
   import gsim_result_fmt_pkg::*;
#(
   parameter int N     = GSIM_N,
   parameter int IN_W  = GSIM_IN_W,
   parameter int FRAC  = GSIM_FRAC,
   parameter int OUT_W = GSIM_OUT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  x_in,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic [3:0]       out_idx,
   output logic             out_sat,
   output logic             busy,
   output logic             done
);

   localparam logic [3:0] LAST = 4'(N-1);

   gsim_state_t state;
   gsim_state_t state_nxt;

   logic [3:0]       cap_cnt;
   logic [3:0]       rd_ptr;
   logic [3:0]       rd_nxt;
   logic             store_en;
   logic             last_store;
   logic             xfer;
   logic             last_xfer;
   logic [OUT_W-1:0] conv_val;
   logic             conv_sat;
   logic [OUT_W-1:0] data_q;
   logic             sat_q;

   // Each entry keeps the saturation flag alongside the integer value.
   logic [OUT_W:0]   mem [N];

   q_round_sat #(
      .IN_W  (IN_W),
      .FRAC  (FRAC),
      .OUT_W (OUT_W)
   ) u_round (
      .x_in  (x_in),
      .q_val (conv_val),
      .q_sat (conv_sat)
   );

   assign rd_nxt = rd_ptr + 4'd1;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and datapath strobes; input words after the frame is full are simply not stored.
   always_comb begin
      state_nxt  = state;
      store_en   = 1'b0;
      last_store = 1'b0;
      xfer       = 1'b0;
      last_xfer  = 1'b0;
      case (state)
         ST_IDLE, ST_CAPTURE: begin
            if (in_valid) begin
               store_en = 1'b1;
               if (cap_cnt == LAST) begin
                  last_store = 1'b1;
                  state_nxt  = ST_DRAIN;
               end else begin
                  state_nxt  = ST_CAPTURE;
               end
            end
         end
         ST_DRAIN: begin
            if (out_ready) begin
               xfer = 1'b1;
               if (rd_ptr == LAST) begin
                  last_xfer = 1'b1;
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_DONE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Frame buffer: written once per accepted word, contents need no reset.
   always_ff @(posedge clk) begin
      if (store_en) begin
         mem[cap_cnt] <= {conv_sat, conv_val};
      end
   end

   // Counters and output holding register; the head word is preloaded as the frame completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_cnt <= 4'd0;
         rd_ptr  <= 4'd0;
         data_q  <= '0;
         sat_q   <= 1'b0;
      end else begin
         if (store_en) begin
            cap_cnt <= cap_cnt + 4'd1;
         end
         if (last_store) begin
            // A single-word frame has no earlier entry to read back.
            if (cap_cnt == 4'd0) begin
               {sat_q, data_q} <= {conv_sat, conv_val};
            end else begin
               {sat_q, data_q} <= mem[0];
            end
         end
         if (xfer) begin
            rd_ptr <= rd_nxt;
            if (!last_xfer) begin
               {sat_q, data_q} <= mem[rd_nxt];
            end
         end
      end
   end

   assign out_valid = (state == ST_DRAIN);
   assign out_data  = data_q;
   assign out_sat   = sat_q;
   assign out_idx   = rd_ptr;
   assign busy      = (state == ST_CAPTURE) || (state == ST_DRAIN);
   assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_gsim_result_fmt.sv
// Self-checking bench for gsim_result_fmt: directed frames plus randomized words and handshakes.
// Expected values come from a real-arithmetic rounding model and a per-frame expectation table.
// Outputs are sampled on the falling edge; inputs are driven right after sampling.
module tb_gsim_result_fmt;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] x_in;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic [3:0]  out_idx;
   logic        out_sat;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   logic [31:0] in_words [16];
   int          exp_data [16];
   bit          exp_sat  [16];
   int          k_stream;
   bit          stream_on;

   gsim_result_fmt dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .x_in      (x_in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_sat   (out_sat),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Nearest integer with ties toward +inf, then clip to the signed 16-bit range.
   function automatic void model(input logic [31:0] x, output int v, output bit s);
      real r;
      r = $floor($itor($signed(x)) / 65536.0 + 0.5);
      if (r > 32767.0) begin
         v = 32767;
         s = 1'b1;
      end else if (r < -32768.0) begin
         v = -32768;
         s = 1'b1;
      end else begin
         v = $rtoi(r);
         s = 1'b0;
      end
   endfunction

   task automatic rand_words();
      for (int i = 0; i < 16; i++) begin
         logic [31:0] w;
         w = $urandom;
         if (i % 2 == 1) w = {{8{w[23]}}, w[23:0]};
         in_words[i] = w;
      end
   endtask

   // Either the overrun stream (k<<16 up to 40 words) or random solver chatter.
   task automatic drive_stream();
      if (stream_on) begin
         if (k_stream < 40) begin
            in_valid = 1'b1;
            x_in     = k_stream << 16;
            k_stream++;
         end else begin
            in_valid = 1'b0;
         end
      end else begin
         in_valid = 1'($urandom_range(0, 1));
         x_in     = $urandom;
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_data"},  out_data, 0);
      chk({tag, "_idx"},   out_idx, 0);
      chk({tag, "_sat"},   out_sat, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_done"},  done, 0);
      reset = 1'b0;
   endtask

   // Present in_words; gap_mode=1 uses the 1,0,0 pattern. out_valid must stay low throughout.
   task automatic feed(input bit gap_mode);
      int  i   = 0;
      int  cyc = 0;
      bit  acc;
      for (int j = 0; j < 16; j++) model(in_words[j], exp_data[j], exp_sat[j]);
      while (i < 16 && cyc < 200) begin
         @(negedge clk);
         chk("cap_valid", out_valid, 0);
         chk("cap_busy", busy, (i > 0) ? 1 : 0);
         acc       = gap_mode ? (cyc % 3 == 0) : 1'b1;
         in_valid  = acc;
         out_ready = 1'($urandom_range(0, 1));
         x_in      = acc ? in_words[i] : $urandom;
         if (acc) i++;
         cyc++;
      end
      if (i < 16) chk("feed_timeout", i, 16);
   endtask

   // ready_mode: 0 always ready, 1 five stall cycles then random, 2 random.
   task automatic drain(input int ready_mode, input int max_xfer);
      int n     = 0;
      int cyc   = 0;
      bit rdy;
      while (n < max_xfer && cyc < 300) begin
         @(negedge clk);
         if (cyc == 0) chk("latency_valid", out_valid, 1);
         else          chk("drain_valid", out_valid, 1);
         chk("drain_busy", busy, 1);
         chk("drain_done", done, 0);
         chk("drain_idx",  out_idx, n);
         chk("drain_data", $signed(out_data), exp_data[n]);
         chk("drain_sat",  out_sat, exp_sat[n]);
         case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         out_ready = rdy;
         if (out_valid && rdy) n++;
         drive_stream();
         cyc++;
      end
      if (n < max_xfer) chk("drain_timeout", n, max_xfer);
   endtask

   task automatic check_done(input int cycles);
      repeat (cycles) begin
         @(negedge clk);
         chk("done_valid", out_valid, 0);
         chk("done_flag", done, 1);
         chk("done_busy", busy, 0);
         out_ready = 1'($urandom_range(0, 1));
         drive_stream();
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      x_in      = '0;
      out_ready = 1'b0;
      stream_on = 1'b0;
      k_stream  = 0;

      do_reset("rst0");

      // Rounding of halves and just-below-half.
      for (int i = 0; i < 16; i++) in_words[i] = 32'h0;
      in_words[0] = 32'h0001_8000;
      in_words[1] = 32'hFFFE_8000;
      in_words[2] = 32'h0000_7FFF;
      feed(1'b0);
      drain(0, 16);
      check_done(3);

      // Saturation at both rails and the largest value that rounds without clipping.
      do_reset("rst1");
      rand_words();
      in_words[0] = 32'h7FFF_8000;
      in_words[1] = 32'h8000_0000;
      in_words[2] = 32'h7FFF_0000;
      in_words[3] = 32'h8000_8000;
      in_words[4] = 32'h7FFF_7FFF;
      feed(1'b0);
      drain(0, 16);
      check_done(2);

      // Backpressure: initial stall then random ready.
      do_reset("rst2");
      rand_words();
      feed(1'b0);
      drain(1, 16);
      check_done(2);

      // Overrun: 40 consecutive words k<<16, only the first 16 may appear.
      do_reset("rst3");
      for (int k = 0; k < 16; k++) in_words[k] = k << 16;
      feed(1'b0);
      k_stream  = 16;
      stream_on = 1'b1;
      drain(0, 16);
      check_done(12);
      stream_on = 1'b0;

      // Gapped input.
      do_reset("rst4");
      rand_words();
      feed(1'b1);
      drain(2, 16);
      check_done(2);

      // Reset in the middle of a drain, then a fresh frame.
      do_reset("rst5");
      rand_words();
      feed(1'b0);
      drain(2, 7);
      do_reset("rst_mid");
      rand_words();
      feed(1'b0);
      drain(2, 16);
      check_done(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
